// File: rtl/softmax_ctrl_if.sv
// Signal bundle between softmax_ctrl and its score buffer, softmax engine and result buffer.
// master = the controller side, slave = the environment side.
interface softmax_ctrl_if;
    logic         go;
    logic [3:0]   num_blk;
    logic         busy;
    logic         done;
    logic         rd_en;
    logic [7:0]   rd_addr;
    logic [639:0] rd_data;
    logic         sm_start;
    logic [639:0] sm_data;
    logic [127:0] sm_y;
    logic [479:0] sm_runmax;
    logic         sm_y_valid;
    logic [143:0] sm_denom;
    logic         sm_denom_valid;
    logic         wr_en;
    logic [7:0]   wr_addr;
    logic [127:0] wr_y;
    logic [479:0] wr_runmax;
    logic [143:0] denom;
    logic         err;

    modport master (
        input  go, num_blk, rd_data, sm_y, sm_runmax, sm_y_valid, sm_denom, sm_denom_valid,
        output busy, done, rd_en, rd_addr, sm_start, sm_data, wr_en, wr_addr, wr_y, wr_runmax,
               denom, err
    );

    modport slave (
        output go, num_blk, rd_data, sm_y, sm_runmax, sm_y_valid, sm_denom, sm_denom_valid,
        input  busy, done, rd_en, rd_addr, sm_start, sm_data, wr_en, wr_addr, wr_y, wr_runmax,
               denom, err
    );
endinterface

// File: rtl/softmax_ctrl.sv
// Row sequencer for a 16-beat softmax engine: streams score blocks in, collects y beats and the
// row denominator. Optional watchdog enabled by defining SOFTMAX_CTRL_WATCHDOG_EN.
module softmax_ctrl #(
    parameter int BLK_BEATS = 16,
    parameter int GAP       = 32,
    parameter int TIMEOUT   = 1024
) (
    input logic            clk,
    input logic            rst_n,
    softmax_ctrl_if.master bus
);
    localparam int GAP_W = $clog2(GAP + 1);

    if (BLK_BEATS != 16 || GAP < 1 || TIMEOUT < 2) begin : g_param_check
        $error("softmax_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FEED, S_WAIT_Y, S_GAP, S_WAIT_DEN, S_DONE
    } state_t;

    state_t             state;
    logic [3:0]         n_blk;
    logic [3:0]         blk;
    logic [3:0]         blk_nxt;
    logic [3:0]         beat;
    logic [7:0]         wr_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               den_seen;
    logic               busy_q;
    logic               done_q;
    logic               rd_en_q;
    logic               sm_start_q;
    logic [7:0]         rd_addr_q;
    logic [143:0]       denom_q;
    logic               wr_fire;
    logic               den_cap;
    logic               blk_done;

    // Writes are capped at the row's beat count; surplus y beats are simply dropped.
    assign wr_fire  = busy_q && bus.sm_y_valid && (wr_cnt < {n_blk, 4'b0000});
    assign den_cap  = busy_q && bus.sm_denom_valid;
    assign blk_nxt  = blk + 4'd1;
    assign blk_done = wr_cnt >= {blk_nxt, 4'b0000};

`ifdef SOFTMAX_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            wd_hit;
    assign wd_hit  = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // NOTE: every register here is updated with <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            n_blk      <= '0;
            blk        <= '0;
            beat       <= '0;
            wr_cnt     <= '0;
            gap_cnt    <= '0;
            den_seen   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            sm_start_q <= 1'b0;
            rd_addr_q  <= '0;
            denom_q    <= '0;
`ifdef SOFTMAX_CTRL_WATCHDOG_EN
            wd_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            sm_start_q <= 1'b0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            if (wr_fire) wr_cnt <= wr_cnt + 8'd1;
            if (den_cap) begin
                denom_q  <= bus.sm_denom;
                den_seen <= 1'b1;
            end
`ifdef SOFTMAX_CTRL_WATCHDOG_EN
            err_q <= 1'b0;
            if (wr_fire || den_cap || (state != S_WAIT_Y && state != S_WAIT_DEN)) wd_cnt <= '0;
            else wd_cnt <= wd_cnt + WD_W'(1);
`endif
            unique case (state)
                S_IDLE: begin
                    if (bus.go && bus.num_blk != 4'd0) begin
                        state      <= S_START;
                        n_blk      <= bus.num_blk;
                        blk        <= '0;
                        wr_cnt     <= '0;
                        den_seen   <= 1'b0;
                        denom_q    <= '0;
                        busy_q     <= 1'b1;
                        sm_start_q <= 1'b1;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= '0;
                    end
                end
                S_START: begin
                    state     <= S_FEED;
                    beat      <= '0;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= rd_addr_q + 8'd1;
                end
                S_FEED: begin
                    beat <= beat + 4'd1;
                    // One read already issued in START, so only 15 more are needed.
                    if (beat < 4'd14) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + 8'd1;
                    end
                    if (beat == 4'd15) state <= S_WAIT_Y;
                end
                S_WAIT_Y: begin
                    if (blk_done) begin
                        if (blk_nxt < n_blk) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= S_WAIT_DEN;
                        end
`ifdef SOFTMAX_CTRL_WATCHDOG_EN
                        wd_cnt <= '0;
                    end else if (wd_hit) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        state      <= S_START;
                        blk        <= blk_nxt;
                        sm_start_q <= 1'b1;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= {blk_nxt, 4'b0000};
                    end
                end
                S_WAIT_DEN: begin
                    if (den_seen || den_cap) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef SOFTMAX_CTRL_WATCHDOG_EN
                    end else if (wd_hit) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
`endif
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.sm_start  = sm_start_q;
    assign bus.sm_data   = (state == S_FEED) ? bus.rd_data : '0;
    assign bus.wr_en     = wr_fire;
    assign bus.wr_addr   = wr_cnt;
    assign bus.wr_y      = bus.sm_y;
    assign bus.wr_runmax = bus.sm_runmax;
    assign bus.denom     = denom_q;
endmodule

// File: tb/tb_softmax_ctrl.sv
// Randomized bench for softmax_ctrl: a score-buffer/softmax-engine responder plus a row-level
// reference model (expected read order, feed data, write stream, denominator, timing bounds).
module tb_softmax_ctrl;
    localparam int GAP     = 32;
    localparam int TIMEOUT = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    softmax_ctrl_if bus ();

    softmax_ctrl #(.BLK_BEATS(16), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] y;
        logic [479:0] rm;
    } ybeat_t;

    typedef struct {
        int     addr;
        ybeat_t b;
        int     c;
    } wr_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [639:0] mem [256];
    int           y_at[$];
    ybeat_t       drv_q[$];
    int           den_at  = -1;
    int           den_cyc = -1;
    logic [143:0] den_val = '0;
    int           lat     = 20;
    bit           early   = 1'b0;
    bit           no_y    = 1'b0;
    int           cur_n   = 0;
    logic         rd_en_prev   = 1'b0;
    logic [7:0]   rd_addr_prev = '0;

    int           rd_q[$];
    logic [639:0] feed_q[$];
    int           start_q[$];
    wr_t          wr_q[$];
    int           done_q[$];
    int           err_q[$];
    int           feed_left = 0;
    int           nz_out = 0;
    int           start_idle_busy = 0;

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [639:0] rand640();
        logic [639:0] r;
        for (int w = 0; w < 20; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_records();
        rd_q.delete(); feed_q.delete(); start_q.delete(); wr_q.delete();
        done_q.delete(); err_q.delete(); drv_q.delete(); y_at.delete();
        feed_left = 0; nz_out = 0; start_idle_busy = 0;
        den_at = -1; den_cyc = -1; den_val = '0;
    endtask

    // Environment: score buffer with 1-cycle read latency, softmax engine emitting y beats
    // a fixed latency after each fed beat, and the row denominator.
    initial begin
        ybeat_t yb;
        for (int a = 0; a < 256; a++) mem[a] = rand640();
        bus.rd_data = '0; bus.sm_y = '0; bus.sm_runmax = '0; bus.sm_y_valid = 1'b0;
        bus.sm_denom = '0; bus.sm_denom_valid = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.rd_data = rd_en_prev ? mem[rd_addr_prev] : rand640();
            while (y_at.size() > 0 && y_at[0] < cyc) void'(y_at.pop_front());
            if (y_at.size() > 0 && y_at[0] == cyc) begin
                void'(y_at.pop_front());
                yb = ybeat_t'(rand640());
                bus.sm_y_valid = 1'b1;
                bus.sm_y       = yb.y;
                bus.sm_runmax  = yb.rm;
                drv_q.push_back(yb);
            end else begin
                bus.sm_y_valid = 1'b0;
                bus.sm_y       = rand640();
                bus.sm_runmax  = rand640();
            end
            if (cyc == den_at) begin
                den_val = rand640();
                den_cyc = cyc;
                bus.sm_denom_valid = 1'b1;
                bus.sm_denom = den_val;
            end else begin
                bus.sm_denom_valid = 1'b0;
                bus.sm_denom = rand640();
            end
        end
    end

    // Monitor: samples DUT outputs mid-cycle and schedules the engine's responses.
    initial begin
        wr_t w;
        int  last_y;
        forever begin
            @(negedge clk);
            rd_en_prev   = bus.rd_en;
            rd_addr_prev = bus.rd_addr;
            if (bus.rd_en) rd_q.push_back(int'(bus.rd_addr));
            if (feed_left > 0) begin
                feed_q.push_back(bus.sm_data);
                feed_left--;
            end else if (bus.sm_data != '0) begin
                nz_out++;
            end
            if (bus.sm_start) begin
                start_q.push_back(cyc);
                if (!bus.busy) start_idle_busy++;
                feed_left = 16;
                if (!no_y) begin
                    for (int j = 0; j < 16; j++) y_at.push_back(cyc + 1 + lat + j);
                    if (start_q.size() == cur_n) begin
                        last_y = cyc + lat + 16;
                        if (early) begin
                            den_at = last_y - 5;
                            for (int j = 1; j <= 3; j++) y_at.push_back(last_y + j);
                        end else begin
                            den_at = last_y + 2 + int'($urandom_range(0, 5));
                        end
                    end
                end
            end
            if (bus.wr_en) begin
                w.addr = int'(bus.wr_addr);
                w.b    = {bus.wr_y, bus.wr_runmax};
                w.c    = cyc;
                wr_q.push_back(w);
            end
            if (bus.done) done_q.push_back(cyc);
            if (bus.err) err_q.push_back(cyc);
        end
    end

    task automatic pulse_go(input int n, output int go_cyc);
        @(posedge clk); #1;
        bus.go = 1'b1; bus.num_blk = 4'(n); go_cyc = cyc;
        @(posedge clk); #1;
        bus.go = 1'b0; bus.num_blk = 4'($urandom_range(0, 15));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"}, bus.busy, 0);
        check({pfx, "_done"}, bus.done, 0);
        check({pfx, "_err"}, bus.err, 0);
        check({pfx, "_rd_en"}, bus.rd_en, 0);
        check({pfx, "_rd_addr"}, bus.rd_addr, 0);
        check({pfx, "_sm_start"}, bus.sm_start, 0);
        check({pfx, "_sm_data"}, bus.sm_data, 0);
        check({pfx, "_wr_en"}, bus.wr_en, 0);
        check({pfx, "_wr_addr"}, bus.wr_addr, 0);
        check({pfx, "_denom"}, bus.denom, 0);
    endtask

    task automatic run_row(input int n, input int l, input bit e, input bit poke);
        int go_cyc;
        int budget;
        bit got_done;
        clear_records();
        cur_n = n; lat = l; early = e; no_y = 1'b0;
        pulse_go(n, go_cyc);
        budget = n * (16 + l + GAP + 40) + 200;
        got_done = 1'b0;
        for (int c = 0; c < budget && !got_done; c++) begin
            @(negedge clk);
            if (poke && c == 30) begin bus.go = 1'b1; bus.num_blk = 4'd7; end
            if (poke && c == 31) bus.go = 1'b0;
            got_done = (done_q.size() > 0);
        end
        repeat (6) @(negedge clk);
        check($sformatf("n%0d_done_seen", n), done_q.size() > 0, 1);
        check("done_count", done_q.size(), 1);
        check("err_count", err_q.size(), 0);
        check("start_count", start_q.size(), n);
        if (start_q.size() > 0) check("start_latency", start_q[0], go_cyc + 1);
        check("start_busy", start_idle_busy, 0);
        check("rd_count", rd_q.size(), 16 * n);
        for (int k = 0; k < rd_q.size() && k < 16 * n; k++)
            check($sformatf("rd_addr[%0d]", k), rd_q[k], k);
        check("feed_count", feed_q.size(), 16 * n);
        for (int k = 0; k < feed_q.size() && k < 16 * n; k++)
            check($sformatf("feed_data[%0d]", k), feed_q[k], mem[k]);
        check("sm_data_zero_outside_feed", nz_out, 0);
        check("wr_count", wr_q.size(), 16 * n);
        for (int k = 0; k < wr_q.size() && k < drv_q.size(); k++) begin
            check($sformatf("wr_addr[%0d]", k), wr_q[k].addr, k);
            check($sformatf("wr_data[%0d]", k), wr_q[k].b, drv_q[k]);
        end
        if (wr_q.size() == 16 * n && start_q.size() == n) begin
            for (int b = 1; b < n; b++)
                check($sformatf("gap_blk%0d", b), (start_q[b] - wr_q[16*b-1].c) >= GAP + 1, 1);
            if (done_q.size() > 0) begin
                if (!e) check("done_after_denom", done_q[0], den_cyc + 1);
                else check("done_after_last_wr", done_q[0] > wr_q[16*n-1].c, 1);
            end
        end
        check("denom", bus.denom, den_val);
        check("busy_after_done", bus.busy, 0);
    endtask

    initial begin
        int go_cyc;
        bus.go = 1'b0;
        bus.num_blk = '0;
        clear_records();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_row(1, 20, 1'b0, 1'b0);
        run_row(4, 11, 1'b0, 1'b0);

        // num_blk == 0 is ignored
        clear_records(); cur_n = 0;
        pulse_go(0, go_cyc);
        repeat (20) @(negedge clk);
        check("zero_blk_starts", start_q.size(), 0);
        check("zero_blk_reads", rd_q.size(), 0);
        check("zero_blk_busy", bus.busy, 0);

        // go (with a different num_blk) while busy is ignored
        run_row(3, 7, 1'b0, 1'b1);

        // reset during FEED of block 2
        clear_records(); cur_n = 4; lat = 6; early = 1'b0; no_y = 1'b0;
        pulse_go(4, go_cyc);
        for (int c = 0; c < 400 && start_q.size() < 2; c++) @(negedge clk);
        check("rst_reached_blk2", start_q.size() >= 2, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        y_at.delete(); den_at = -1;
        #1 check_all_zero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_q.size(), 0);
        run_row(2, 5, 1'b0, 1'b0);

        // denominator before the last y beat, plus 3 surplus y beats
        run_row(2, 9, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++)
            run_row(int'($urandom_range(1, 15)), int'($urandom_range(1, 30)),
                    1'($urandom_range(0, 1)), 1'b0);

        // engine never answers
        clear_records(); cur_n = 1; no_y = 1'b1;
        pulse_go(1, go_cyc);
`ifdef SOFTMAX_CTRL_WATCHDOG_EN
        for (int c = 0; c < TIMEOUT + 200 && err_q.size() == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("wd_err_count", err_q.size(), 1);
        if (err_q.size() > 0 && start_q.size() > 0)
            check("wd_err_cycle", err_q[0], start_q[0] + 17 + TIMEOUT);
        check("wd_busy_low", bus.busy, 0);
        check("wd_no_done", done_q.size(), 0);
`else
        repeat (300) @(negedge clk);
        check("hang_busy", bus.busy, 1);
        check("hang_no_done", done_q.size(), 0);
        check("hang_err", bus.err, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("hang_rst_busy", bus.busy, 0);
`endif
        no_y = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/softmax_ctrl.md
SOFTMAX_CTRL -- requirements
Module: softmax_ctrl

Interface
REQ-001 Parameter BLK_BEATS, 16, data beats per softmax block (fixed at 16).
REQ-002 Parameter GAP, 32, minimum idle cycles between the last y write of one block and the next o_sm_start.
REQ-003 Parameter TIMEOUT, 1024, watchdog limit in cycles; used only with the Configuration macro.
REQ-004 i_clk  in  1  clock, all logic rising-edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_go  in  1  one-cycle request to process one row.
REQ-007 i_num_blk  in  4  blocks in the row (1..15).
REQ-008 o_busy  out  1  high from accepted i_go until o_done/o_err.
REQ-009 o_done  out  1  one-cycle pulse, row complete.
REQ-010 o_rd_en / o_rd_addr  out  1 / 8  score-buffer read; data on i_rd_data 1 cycle later.
REQ-011 i_rd_data  in  640  16 lanes x 40-bit scores.
REQ-012 o_sm_start / o_sm_data  out  1 / 640  softmax start pulse and data beats.
REQ-013 i_sm_y / i_sm_runmax / i_sm_y_valid  in  128 / 480 / 1  softmax per-beat outputs.
REQ-014 i_sm_denom / i_sm_denom_valid  in  144 / 1  softmax row denominator.
REQ-015 o_wr_en / o_wr_addr / o_wr_y / o_wr_runmax  out  1 / 8 / 128 / 480  result-buffer write.
REQ-016 o_denom  out  144  captured denominator, held until next accepted i_go.
REQ-017 o_err  out  1  one-cycle watchdog abort pulse (0 when macro absent).

Function
REQ-018 FSM states IDLE, START, FEED, WAIT_Y, GAP, WAIT_DEN, DONE.
REQ-019 IDLE: i_go with i_num_blk!=0 -> START, o_denom cleared, block, read, write counters cleared; i_go with i_num_blk==0, or i_go while busy, is ignored.
REQ-020 START (1 cycle): o_sm_start=1, o_rd_en=1, o_rd_addr=blk*16 -> FEED.
REQ-021 FEED (16 cycles): o_sm_data=i_rd_data each cycle; o_rd_en=1 on first 15 FEED cycles with o_rd_addr incrementing by 1; o_sm_data=0 outside FEED.
REQ-022 After FEED -> WAIT_Y until the block's 16 y beats are written.
REQ-023 Every i_sm_y_valid cycle while o_busy and write count < 16*i_num_blk: o_wr_en=1, o_wr_addr=write count, o_wr_y/o_wr_runmax = inputs combinationally, write count +1; y beats in other cases are dropped.
REQ-024 WAIT_Y complete: if more blocks remain -> GAP (GAP cycles) -> START with blk+1; else -> WAIT_DEN.
REQ-025 i_sm_denom_valid while o_busy captures i_sm_denom into o_denom (last capture wins); WAIT_DEN exits on the capture or if it occurred earlier in the row.
REQ-026 DONE (1 cycle): o_done=1, o_busy=0 -> IDLE.
REQ-027 i_num_blk latched at accepted i_go; changes while busy have no effect.

Reset
REQ-028 On i_rst_n low, immediately: state IDLE, all counters 0, o_busy, o_done, o_err, o_rd_en, o_sm_start, o_wr_en=0, o_rd_addr, o_wr_addr, o_sm_data, o_denom=0.
REQ-029 Reset mid-row aborts without o_done; operation resumes only on a new i_go after release.

Configuration
REQ-030 Macro SOFTMAX_CTRL_WATCHDOG_EN defined: cycle counter clears on every y write/denom capture and state change, runs in WAIT_Y and WAIT_DEN; reaching TIMEOUT -> o_err pulse 1 cycle, return to IDLE, no o_done.
REQ-031 Macro not defined: no watchdog logic, o_err tied 0, WAIT_Y/WAIT_DEN wait indefinitely.

Verification
REQ-032 i_go, i_num_blk=1, softmax model y-latency 20 -> o_sm_start at cycle 1, 16 reads addr 0..15, 16 writes addr 0..15, o_done 1 cycle after denom capture.
REQ-033 i_num_blk=4 -> 4 start pulses each >= GAP+1 cycles after previous block's last write, reads/writes 0..63, one o_done.
REQ-034 i_go with i_num_blk=0, and i_go while busy -> no state change, no reads.
REQ-035 i_rst_n low during FEED of block 2 -> all outputs 0 same time, no o_done; fresh i_go then runs normally from addr 0.
REQ-036 Macro defined, TIMEOUT=64, model never asserts y_valid -> o_err at 64 cycles into WAIT_Y, o_busy falls, no o_done; macro undefined -> o_busy stays 1.
REQ-037 denom_valid arriving before last y beat, plus 3 extra y beats -> o_denom captured, extras not written, o_done after final expected write.
